alu_multicycle: RTL

//  Parametrised multi-cycle ALU; successor to the single-cycle combinational ALU.

---
 rtl/alu_multicycle.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: base ops register on the accept edge (latency 1); MUL/DIVU/REMU iterate
// one bit per cycle (latency WIDTH+1). start is accepted only in IDLE/DONE and ignored while busy.
module alu_multicycle #(
  parameter int WIDTH      = 32,
  parameter bit DIV_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             LesserThan
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] NBITS = CW'(WIDTH);
  localparam logic [CW-1:0] ONE   = CW'(1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;     // MUL: partial product; DIV: remainder
  logic [WIDTH-1:0] opa;     // MUL: shifting multiplicand; DIV: dividend/quotient
  logic [WIDTH-1:0] opb;     // MUL: shifting multiplier; DIV: divisor
  logic             op_rem;
  logic             lt_cap;

  logic             accept, to_mul, to_div, last, lt_in;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] quick;
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH-1:0] rem_sh, rem_nxt, quo_nxt, div_res;
  logic             rem_ge;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign to_mul = (ALUControl == OP_MUL);
  assign to_div = DIV_ENABLE && ((ALUControl == OP_DIVU) || (ALUControl == OP_REMU))
                  && (srcB != '0);
  assign last   = (count == ONE);
  assign lt_in  = $signed(srcA) < $signed(srcB);
  assign shamt  = srcB[SHW-1:0];

  // Single-cycle results; DIVU/REMU only land here for the divide-by-zero case.
  always_comb begin
    quick = '0;
    case (ALUControl)
      OP_ADD:  quick = srcA + srcB;
      OP_SUB:  quick = srcA - srcB;
      OP_AND:  quick = srcA & srcB;
      OP_OR:   quick = srcA | srcB;
      OP_XOR:  quick = srcA ^ srcB;
      OP_SLT:  quick = {{(WIDTH-1){1'b0}}, lt_in};
      OP_SLL:  quick = srcA << shamt;
      OP_SRL:  quick = srcA >> shamt;
      OP_SRA:  quick = $signed(srcA) >>> shamt;
      OP_SLTU: quick = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
      OP_DIVU: if (DIV_ENABLE) quick = '1;
      OP_REMU: if (DIV_ENABLE) quick = srcA;
      default: quick = '0;
    endcase
  end

  assign mul_acc_nxt = opb[0] ? (acc + opa) : acc;

  // Restoring step; a set remainder MSB means the shifted value already exceeds any divisor.
  assign rem_sh  = {acc[WIDTH-2:0], opa[WIDTH-1]};
  assign rem_ge  = acc[WIDTH-1] || (rem_sh >= opb);
  assign rem_nxt = rem_ge ? (rem_sh - opb) : rem_sh;
  assign quo_nxt = {opa[WIDTH-2:0], rem_ge};
  assign div_res = op_rem ? rem_nxt : quo_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          if (to_mul)      state_nxt = MUL;
          else if (to_div) state_nxt = DIV;
          else             state_nxt = DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      MUL, DIV: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      acc        <= '0;
      opa        <= '0;
      opb        <= '0;
      op_rem     <= 1'b0;
      lt_cap     <= 1'b0;
      ALUOut     <= '0;
      Zero       <= 1'b0;
      LesserThan <= 1'b0;
    end else if (accept) begin
      acc    <= '0;
      opa    <= srcA;
      opb    <= srcB;
      op_rem <= (ALUControl == OP_REMU);
      lt_cap <= lt_in;
      if (to_mul || to_div) begin
        count <= NBITS;
      end else begin
        ALUOut     <= quick;
        Zero       <= (quick == '0);
        LesserThan <= lt_in;
      end
    end else if (state == MUL) begin
      acc   <= mul_acc_nxt;
      opa   <= opa << 1;
      opb   <= opb >> 1;
      count <= count - ONE;
      if (last) begin
        ALUOut     <= mul_acc_nxt;
        Zero       <= (mul_acc_nxt == '0);
        LesserThan <= lt_cap;
      end
    end else if (state == DIV) begin
      acc   <= rem_nxt;
      opa   <= quo_nxt;
      count <= count - ONE;
      if (last) begin
        ALUOut     <= div_res;
        Zero       <= (div_res == '0);
        LesserThan <= lt_cap;
      end
    end
  end
endmodule
